// File: rtl/hdb3_tx_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdb3_tx_sched_if : NRZ input handshake and P/N rail bundle            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface hdb3_tx_sched_if;
  logic en;
  logic din;
  logic din_valid;
  logic din_ready;
  logic data_outP;
  logic data_outN;
  logic sym_strobe;
  logic underrun;
  logic busy;

  modport master (
    output en, din, din_valid,
    input  din_ready, data_outP, data_outN, sym_strobe, underrun, busy
  );

  modport slave (
    input  en, din, din_valid,
    output din_ready, data_outP, data_outN, sym_strobe, underrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/hdb3_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdb3_tx_sched : paced HDB3 encoder driving the P/N line rails         |
// | Build option HDB3_RZ_EN : return-to-zero rails (half-symbol pulses)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hdb3_tx_sched #(
  parameter int DIV = 16
) (
  input  logic           clk,
  input  logic           rst,
  hdb3_tx_sched_if.slave bus
);
  localparam int            CW         = $clog2(DIV);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(DIV - 1);
`ifdef HDB3_RZ_EN
  localparam logic [CW-1:0] c_CNT_HALF = CW'(DIV / 2 - 1);
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Symbol codes share the rail encoding {P,N}
  localparam logic [1:0] c_ZERO = 2'b00;
  localparam logic [1:0] c_POS  = 2'b10;
  localparam logic [1:0] c_NEG  = 2'b01;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_drain;
  logic [1:0]    r_s0, r_s1, r_s2;
  logic [1:0]    r_rail;
  logic          r_last_pos;
  logic          r_par_odd;
  logic [1:0]    r_zrun;

  logic       w_active, w_tick, w_run_tick, w_drain_end, w_bit;
  logic [1:0] w_code, w_s3_new, w_zrun_n;
  logic       w_last_n, w_par_n;

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_tick      = w_active && (r_cnt == c_CNT_LAST);
  assign w_run_tick  = w_tick && (r_state == S_RUN);
  assign w_drain_end = w_tick && (r_state == S_DRAIN) && (r_drain == 2'd2);
  assign w_bit       = w_run_tick && bus.din_valid && bus.din;

  // Encoder: w_s3_new is the post-shift s3, overwritten with B on B00V
  always_comb begin
    w_code   = c_ZERO;
    w_s3_new = r_s2;
    w_last_n = r_last_pos;
    w_par_n  = r_par_odd;
    w_zrun_n = r_zrun;
    if (w_bit) begin
      w_code   = r_last_pos ? c_NEG : c_POS;
      w_last_n = ~r_last_pos;
      w_par_n  = ~r_par_odd;
      w_zrun_n = 2'd0;
    end else if (r_zrun != 2'd3) begin
      w_zrun_n = r_zrun + 2'd1;
    end else if (r_par_odd) begin
      w_code   = r_last_pos ? c_POS : c_NEG;
      w_par_n  = 1'b0;
      w_zrun_n = 2'd0;
    end else begin
      w_code   = r_last_pos ? c_NEG : c_POS;
      w_s3_new = w_code;
      w_last_n = ~r_last_pos;
      w_par_n  = 1'b0;
      w_zrun_n = 2'd0;
    end
  end

  // s3 is not kept separately: r_rail holds it and feeds the rails directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_drain    <= 2'd0;
      r_s0       <= c_ZERO;
      r_s1       <= c_ZERO;
      r_s2       <= c_ZERO;
      r_rail     <= c_ZERO;
      r_last_pos <= 1'b0;
      r_par_odd  <= 1'b0;
      r_zrun     <= 2'd0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (bus.en) r_state <= S_RUN;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      end

      if (w_run_tick && !bus.en) begin
        r_state <= S_DRAIN;
        r_drain <= 2'd0;
      end
      if (w_tick && (r_state == S_DRAIN)) begin
        r_drain <= r_drain + 2'd1;
        if (w_drain_end) r_state <= S_IDLE;
      end

      if (w_tick) begin
        r_last_pos <= w_last_n;
        r_par_odd  <= w_par_n;
        if (w_drain_end) begin
          r_s0   <= c_ZERO;
          r_s1   <= c_ZERO;
          r_s2   <= c_ZERO;
          r_rail <= c_ZERO;
          r_zrun <= 2'd0;
        end else begin
          r_s0   <= w_code;
          r_s1   <= r_s0;
          r_s2   <= r_s1;
          r_rail <= w_s3_new;
          r_zrun <= w_zrun_n;
        end
      end
`ifdef HDB3_RZ_EN
      else if (w_active && (r_cnt == c_CNT_HALF)) begin
        r_rail <= c_ZERO;
      end
`endif
    end
  end

  assign bus.din_ready  = w_run_tick;
  assign bus.sym_strobe = w_tick;
  assign bus.underrun   = w_run_tick && !bus.din_valid;
  assign bus.busy       = w_active;
  assign bus.data_outP  = r_rail[1];
  assign bus.data_outN  = r_rail[0];
endmodule
`default_nettype wire

// File: tb/tb_hdb3_tx_sched.sv
`default_nettype none
// Self-checking bench for hdb3_tx_sched: queue scoreboard of expected rail codes.
module tb_hdb3_tx_sched;
  localparam int DIV = 16;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] N = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  hdb3_tx_sched_if bus();

  hdb3_tx_sched #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: codes waiting to reach the rails, oldest first
  logic [1:0] pend[$];
  logic       m_last_pos;
  logic       m_par_odd;
  int         m_zrun;

  function automatic void model_reset();
    pend.delete();
    for (int i = 0; i < 3; i++) pend.push_back(Z);
    m_last_pos = 1'b0;
    m_par_odd  = 1'b0;
    m_zrun     = 0;
  endfunction

  function automatic logic [1:0] model_step(input logic b, input logic fin);
    logic [1:0] e;
    if (b) begin
      pend.push_back(m_last_pos ? N : P);
      m_last_pos = ~m_last_pos;
      m_par_odd  = ~m_par_odd;
      m_zrun     = 0;
    end else if (m_zrun < 3) begin
      m_zrun++;
      pend.push_back(Z);
    end else begin
      m_zrun = 0;
      if (!m_par_odd) begin
        pend[pend.size() - 3] = m_last_pos ? N : P;
        m_last_pos = ~m_last_pos;
      end
      m_par_odd = 1'b0;
      pend.push_back(m_last_pos ? P : N);
    end
    e = pend.pop_front();
    if (fin) begin
      e = Z;
      pend.delete();
      for (int i = 0; i < 3; i++) pend.push_back(Z);
      m_zrun = 0;
    end
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus.en = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Drives one bit, waits for its symbol tick, returns observations and the model's rail code
  task automatic tick(input logic b, input logic v, input logic drain, input logic fin,
                      output logic ok, output logic rdy, output logic ur, output logic bz,
                      output int cyc, output logic [1:0] rail, output logic [1:0] exp);
    bus.din = b;
    bus.din_valid = v;
    ok = 1'b0; rdy = 1'b0; ur = 1'b0; bz = 1'b0; cyc = 0;
    for (int i = 0; i < 4 * DIV && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.sym_strobe === 1'b1) begin
        ok = 1'b1; rdy = bus.din_ready; ur = bus.underrun; bz = bus.busy;
      end
    end
    @(posedge clk);
    #1;
    rail = {bus.data_outP, bus.data_outN};
    exp = model_step(drain ? 1'b0 : (v & b), fin);
  endtask

  task automatic test_reset();
    int strobes;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.din = 1'b1;
    bus.din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.data_outP, bus.data_outN} !== Z) $display("FAIL reset_rails got %b want %b", {bus.data_outP, bus.data_outN}, Z);
    else passed++;
    total++;
    if ({bus.busy, bus.din_ready, bus.sym_strobe, bus.underrun} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.din_ready, bus.sym_strobe, bus.underrun});
    else passed++;
    do_reset();
    strobes = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (bus.sym_strobe !== 1'b0 || bus.busy !== 1'b0) strobes++;
    end
    total++;
    if (strobes !== 0) $display("FAIL idle_quiet got %0d active cycles want 0", strobes);
    else passed++;
  endtask

  task automatic test_all_ones();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
      total++;
      if (!ok || rdy !== 1'b1 || ur !== 1'b0)
        $display("FAIL ones_hs%0d got ok=%b rdy=%b ur=%b want 1 1 0", k, ok, rdy, ur);
      else passed++;
      total++;
      if (cyc !== ((k == 0) ? DIV + 1 : DIV))
        $display("FAIL ones_period%0d got %0d want %0d", k, cyc, (k == 0) ? DIV + 1 : DIV);
      else passed++;
      total++;
      if (rail !== exp) $display("FAIL ones_rail%0d got %b want %b", k, rail, exp);
      else passed++;
    end
  endtask

  task automatic test_mark_000v();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc;
    logic [11:0] bits;
    bits = 12'b100000000000;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(bits[11 - k], 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
      total++;
      if (!ok || rail !== exp) $display("FAIL mark000v_rail%0d got %b want %b (tick=%b)", k, rail, exp, ok);
      else passed++;
    end
  endtask

  task automatic test_leading_zeros();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
      total++;
      if (!ok || rail !== exp || ur !== 1'b0)
        $display("FAIL zeros_rail%0d got %b ur=%b want %b ur=0", k, rail, ur, exp);
      else passed++;
    end
  endtask

  task automatic test_underrun();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
      total++;
      if (!ok || rdy !== 1'b1 || ur !== 1'b1)
        $display("FAIL underrun_flag%0d got ok=%b rdy=%b ur=%b want 1 1 1", k, ok, rdy, ur);
      else passed++;
      total++;
      if (rail !== exp) $display("FAIL underrun_rail%0d got %b want %b", k, rail, exp);
      else passed++;
    end
  endtask

  task automatic test_drain();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc, strobes;
    do_reset();
    bus.en = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
    bus.en = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
    total++;
    if (!ok || rdy !== 1'b1 || rail !== exp)
      $display("FAIL drain_last_run got ok=%b rdy=%b rail=%b want 1 1 %b", ok, rdy, rail, exp);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b1, (k == 2), ok, rdy, ur, bz, cyc, rail, exp);
      total++;
      if (!ok || rdy !== 1'b0 || ur !== 1'b0 || bz !== 1'b1)
        $display("FAIL drain_tick%0d got ok=%b rdy=%b ur=%b busy=%b want 1 0 0 1", k, ok, rdy, ur, bz);
      else passed++;
      total++;
      if (rail !== exp) $display("FAIL drain_rail%0d got %b want %b", k, rail, exp);
      else passed++;
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL drain_busy got %b want 0", bus.busy);
    else passed++;
    strobes = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (bus.sym_strobe !== 1'b0 || {bus.data_outP, bus.data_outN} !== Z) strobes++;
    end
    total++;
    if (strobes !== 0) $display("FAIL drain_after got %0d active cycles want 0", strobes);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
    total++;
    if (rail !== exp || exp !== N) $display("FAIL areset_before got %b want %b", rail, N);
    else passed++;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.data_outP, bus.data_outN, bus.busy} !== 3'b000)
      $display("FAIL areset_now got rails=%b busy=%b want 00 0", {bus.data_outP, bus.data_outN}, bus.busy);
    else passed++;
  endtask

  task automatic test_hold();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc, n, want;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
    n = 0;
    for (int i = 0; i < DIV; i++) begin
      if ({bus.data_outP, bus.data_outN} === P) n++;
      if (i < DIV - 1) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef HDB3_RZ_EN
    want = DIV / 2;
`else
    want = DIV;
`endif
    total++;
    if (n !== want) $display("FAIL hold_mark got %0d cycles of 10 want %0d", n, want);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic ok, rdy, ur, bz;
    logic [1:0] rail, exp;
    int cyc;
    logic b, v;
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      b = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      tick(b, v, 1'b0, 1'b0, ok, rdy, ur, bz, cyc, rail, exp);
      total++;
      if (!ok || rdy !== 1'b1 || ur !== ~v || rail !== exp)
        $display("FAIL b2b%0d got ok=%b rdy=%b ur=%b rail=%b want 1 1 %b %b", k, ok, rdy, ur, rail, ~v, exp);
      else passed++;
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    model_reset();
    test_reset();
    test_all_ones();
    test_mark_000v();
    test_leading_zeros();
    test_underrun();
    test_drain();
    test_async_reset();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
